// File: rtl/pmem_arbiter_pkg.sv
// Shared types and constants for the physical-memory arbiter.
// Provides the line/word types, the FSM state encoding and the grant type.
package pmem_arbiter_pkg;

    localparam int unsigned ARB_ADDR_WIDTH = 16;
    localparam int unsigned ARB_LINE_WIDTH = 128;
    localparam int unsigned ARB_STATE_W    = 2;

    typedef logic [ARB_ADDR_WIDTH-1:0] lc3b_word;
    typedef lc3b_word                  lc3b_addr;
    typedef logic [ARB_LINE_WIDTH-1:0] lc3b_line;

    // FSM encoding: IDLE, SERVE_I, SERVE_D
    localparam logic [ARB_STATE_W-1:0] ARB_IDLE    = 2'd0;
    localparam logic [ARB_STATE_W-1:0] ARB_SERVE_I = 2'd1;
    localparam logic [ARB_STATE_W-1:0] ARB_SERVE_D = 2'd2;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } lc3b_arb_grant;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of all cache-side and memory-side signals of the arbiter.
// slave  : arbiter view (requests and memory response in, strobes/data out)
// master : environment view (caches and memory)
interface pmem_arbiter_if
    import pmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = ARB_LINE_WIDTH
);
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_arbiter_rr.sv
// Two-input round-robin grant (combinational).
// req[0] = I-cache, req[1] = D-cache; last_grant breaks ties.
// grant_valid_c : any request present
// grant_c       : winning side
module pmem_arbiter_rr
    import pmem_arbiter_pkg::*;
(
    input  logic [1:0]    req,
    input  lc3b_arb_grant last_grant,
    output logic          grant_valid_c,
    output lc3b_arb_grant grant_c
);

    always_comb begin
        grant_valid_c = |req;
        grant_c       = GRANT_I;
        case (req)
            2'b01:   grant_c = GRANT_I;
            2'b10:   grant_c = GRANT_D;
            // tie: favour the side that did not win last time
            2'b11:   grant_c = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
            default: grant_c = GRANT_I;
        endcase
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache.
// clk, reset : clock and synchronous active-high reset
// bus        : cache request/response and memory strobe/data signals
// The granted request is latched in IDLE and held until pmem_resp, then the
// FSM returns to IDLE and re-arbitrates round-robin.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = ARB_LINE_WIDTH
)(
    input  logic          clk,
    input  logic          reset,
    pmem_arbiter_if.slave bus
);

    logic [ARB_STATE_W-1:0] state_q,      state_d;
    lc3b_arb_grant          last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q,       addr_d;
    logic [LINE_WIDTH-1:0]  wdata_q,      wdata_d;
    logic                   op_write_q,   op_write_d;

    logic [1:0]    req_c;
    logic          grant_valid_c;
    lc3b_arb_grant grant_c;

    assign req_c = {bus.d_pmem_read | bus.d_pmem_write, bus.i_pmem_read};

    pmem_arbiter_rr u_rr (
        .req           (req_c),
        .last_grant    (last_grant_q),
        .grant_valid_c (grant_valid_c),
        .grant_c       (grant_c)
    );

    // State and latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_write_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_write_q   <= op_write_d;
        end
    end

    // Next-state and latch-load logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_write_d   = op_write_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid_c) begin
                    last_grant_d = grant_c;
                    if (grant_c == GRANT_D) begin
                        state_d    = ARB_SERVE_D;
                        addr_d     = bus.d_pmem_address;
                        wdata_d    = bus.d_pmem_wdata;
                        // write wins if both read and write are raised
                        op_write_d = bus.d_pmem_write;
                    end else begin
                        state_d    = ARB_SERVE_I;
                        addr_d     = bus.i_pmem_address;
                        wdata_d    = '0;
                        op_write_d = 1'b0;
                    end
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Strobes decode only from flops, so they are glitch-free for memory
    assign bus.pmem_read    = (state_q == ARB_SERVE_I) ||
                              ((state_q == ARB_SERVE_D) && !op_write_q);
    assign bus.pmem_write   = (state_q == ARB_SERVE_D) && op_write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    // Response routed to the side being served; data passes through
    assign bus.i_pmem_resp  = bus.pmem_resp && (state_q == ARB_SERVE_I);
    assign bus.d_pmem_resp  = bus.pmem_resp && (state_q == ARB_SERVE_D);
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;

    // Simultaneous D read and write is illegal
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(bus.d_pmem_read && bus.d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: a per-cycle vector table plus
// hand-written sequences for tie order, dropped request and mid-transfer reset.
module tb_pmem_arbiter;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_5A = {16{8'h5A}};

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pmem_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

    pmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic         i_rd;
        logic         d_rd;
        logic         d_wr;
        logic [15:0]  i_addr;
        logic [15:0]  d_addr;
        logic [127:0] d_wdata;
        logic         mem_resp;
        logic         e_rd;
        logic         e_wr;
        logic [15:0]  e_addr;
        logic [127:0] e_wdata;
        logic         e_iresp;
        logic         e_dresp;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic i_rd, input logic d_rd, input logic d_wr,
                                input logic [15:0] i_addr, input logic [15:0] d_addr,
                                input logic [127:0] d_wdata, input logic mem_resp,
                                input logic e_rd, input logic e_wr, input logic [15:0] e_addr,
                                input logic [127:0] e_wdata, input logic e_iresp,
                                input logic e_dresp);
        vec_t v;
        v.i_rd = i_rd;   v.d_rd = d_rd;     v.d_wr = d_wr;
        v.i_addr = i_addr; v.d_addr = d_addr; v.d_wdata = d_wdata;
        v.mem_resp = mem_resp;
        v.e_rd = e_rd;   v.e_wr = e_wr;     v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_iresp = e_iresp; v.e_dresp = e_dresp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata   = '0;
        bus.pmem_rdata     = '0;
        bus.pmem_resp      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_order[4];
        int n;

        // cycle-by-cycle vectors; outputs reflect state from earlier edges
        tbl[0]  = mk(1,0,0, 16'h1230,16'h0000,'0,     0, 0,0,16'h0000,'0,    0,0);
        tbl[1]  = mk(1,0,0, 16'h1230,16'h0000,'0,     0, 1,0,16'h1230,'0,    0,0);
        tbl[2]  = mk(1,0,0, 16'h1230,16'h0000,'0,     0, 1,0,16'h1230,'0,    0,0);
        tbl[3]  = mk(0,0,0, 16'h1230,16'h0000,'0,     1, 1,0,16'h1230,'0,    1,0);
        tbl[4]  = mk(0,0,0, 16'h0000,16'h0000,'0,     0, 0,0,16'h0000,'0,    0,0);
        tbl[5]  = mk(0,0,1, 16'h0000,16'h4000,PAT_A5, 0, 0,0,16'h0000,'0,    0,0);
        tbl[6]  = mk(0,0,1, 16'h0000,16'h4000,PAT_5A, 0, 0,1,16'h4000,PAT_A5,0,0);
        tbl[7]  = mk(0,0,1, 16'h0000,16'h4000,PAT_5A, 1, 0,1,16'h4000,PAT_A5,0,1);
        tbl[8]  = mk(0,0,0, 16'h0000,16'h0000,'0,     1, 0,0,16'h0000,'0,    0,0);
        tbl[9]  = mk(0,0,0, 16'h0000,16'h0000,'0,     0, 0,0,16'h0000,'0,    0,0);
        tbl[10] = mk(1,1,0, 16'h1230,16'h4000,'0,     0, 0,0,16'h0000,'0,    0,0);
        tbl[11] = mk(1,1,0, 16'h1230,16'h4000,'0,     1, 1,0,16'h1230,'0,    1,0);
        tbl[12] = mk(1,1,0, 16'h1230,16'h4000,'0,     0, 0,0,16'h0000,'0,    0,0);
        tbl[13] = mk(1,1,0, 16'h1230,16'h4000,'0,     1, 1,0,16'h4000,'0,    0,1);
        tbl[14] = mk(0,0,0, 16'h0000,16'h0000,'0,     0, 0,0,16'h0000,'0,    0,0);

        // reset state
        do_reset();
        @(negedge clk);
        chk("reset pmem_read",    128'(bus.pmem_read),    128'(1'b0));
        chk("reset pmem_write",   128'(bus.pmem_write),   128'(1'b0));
        chk("reset pmem_address", 128'(bus.pmem_address), 128'(16'h0000));
        chk("reset pmem_wdata",   bus.pmem_wdata,         128'h0);
        next_cycle();

        for (int k = 0; k < 15; k++) begin
            bus.i_pmem_read    = tbl[k].i_rd;
            bus.d_pmem_read    = tbl[k].d_rd;
            bus.d_pmem_write   = tbl[k].d_wr;
            bus.i_pmem_address = tbl[k].i_addr;
            bus.d_pmem_address = tbl[k].d_addr;
            bus.d_pmem_wdata   = tbl[k].d_wdata;
            bus.pmem_resp      = tbl[k].mem_resp;
            bus.pmem_rdata     = {4{32'hC0DE_0000 + 32'(k)}};
            @(negedge clk);
            chk($sformatf("v%0d pmem_read", k),   128'(bus.pmem_read),   128'(tbl[k].e_rd));
            chk($sformatf("v%0d pmem_write", k),  128'(bus.pmem_write),  128'(tbl[k].e_wr));
            chk($sformatf("v%0d i_pmem_resp", k), 128'(bus.i_pmem_resp), 128'(tbl[k].e_iresp));
            chk($sformatf("v%0d d_pmem_resp", k), 128'(bus.d_pmem_resp), 128'(tbl[k].e_dresp));
            chk($sformatf("v%0d i_pmem_rdata", k), bus.i_pmem_rdata, {4{32'hC0DE_0000 + 32'(k)}});
            chk($sformatf("v%0d d_pmem_rdata", k), bus.d_pmem_rdata, {4{32'hC0DE_0000 + 32'(k)}});
            if (tbl[k].e_rd || tbl[k].e_wr)
                chk($sformatf("v%0d pmem_address", k), 128'(bus.pmem_address), 128'(tbl[k].e_addr));
            if (tbl[k].e_wr)
                chk($sformatf("v%0d pmem_wdata", k), bus.pmem_wdata, tbl[k].e_wdata);
            next_cycle();
        end

        // tie right after reset: D first, then alternating
        do_reset();
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h1230;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h4000;
        exp_order[0] = 16'h4000; exp_order[1] = 16'h1230;
        exp_order[2] = 16'h4000; exp_order[3] = 16'h1230;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (!bus.pmem_read && n < 5) begin
                next_cycle();
                n++;
            end
            chk($sformatf("tie%0d strobe within bound", t), 128'(bus.pmem_read), 128'(1'b1));
            chk($sformatf("tie%0d pmem_address", t), 128'(bus.pmem_address), 128'(exp_order[t]));
            bus.pmem_resp = 1'b1;
            @(negedge clk);
            chk($sformatf("tie%0d i_pmem_resp", t), 128'(bus.i_pmem_resp),
                128'(exp_order[t] == 16'h1230));
            chk($sformatf("tie%0d d_pmem_resp", t), 128'(bus.d_pmem_resp),
                128'(exp_order[t] == 16'h4000));
            next_cycle();
            bus.pmem_resp = 1'b0;
        end

        // I request dropped one cycle after grant
        do_reset();
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h1230;
        next_cycle();
        bus.i_pmem_read = 1'b0;
        chk("drop strobe c1", 128'(bus.pmem_read), 128'(1'b1));
        next_cycle();
        chk("drop strobe c2", 128'(bus.pmem_read), 128'(1'b1));
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        chk("drop i_pmem_resp", 128'(bus.i_pmem_resp), 128'(1'b1));
        next_cycle();
        bus.pmem_resp = 1'b0;
        chk("drop idle read", 128'(bus.pmem_read), 128'(1'b0));
        next_cycle();
        chk("drop no restrobe read",  128'(bus.pmem_read),  128'(1'b0));
        chk("drop no restrobe write", 128'(bus.pmem_write), 128'(1'b0));

        // reset while serving a D write
        do_reset();
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 16'h4000;
        bus.d_pmem_wdata   = PAT_A5;
        next_cycle();
        chk("rst pre write", 128'(bus.pmem_write), 128'(1'b1));
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        bus.d_pmem_write = 1'b0;
        chk("rst write dropped", 128'(bus.pmem_write), 128'(1'b0));
        chk("rst read dropped",  128'(bus.pmem_read),  128'(1'b0));
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        chk("rst late d_resp", 128'(bus.d_pmem_resp), 128'(1'b0));
        chk("rst late i_resp", 128'(bus.i_pmem_resp), 128'(1'b0));
        next_cycle();
        bus.pmem_resp = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
